fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 23 ++
 rtl/fetch_unit_ret_stack.sv | 34 +++
 rtl/fetch_unit.sv | 83 ++++++++
 tb/tb_fetch_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared control opcodes, jump condition codes and FSM state type for the fetch unit
package fetch_unit_pkg;
  typedef enum logic {S_FETCH, S_ISSUE} state_t;
  typedef enum logic [2:0] {CC_EQ, CC_NE, CC_CS, CC_CC, CC_MI, CC_PL, CC_VS, CC_AL} cond_t;
  localparam logic [4:0] OP_JMP  = 5'h1C;
  localparam logic [4:0] OP_BRXX = 5'h1D;
  localparam logic [4:0] OP_CALL = 5'h1E;
  localparam logic [4:0] OP_RET  = 5'h1F;
  // f is {N,C,V,Z}; any code outside the known set is not taken
  function automatic logic cond_taken(cond_t cc, logic [3:0] f);
    case (cc)
      CC_EQ:   return f[0];
      CC_NE:   return !f[0];
      CC_CS:   return f[2];
      CC_CC:   return !f[2];
      CC_MI:   return f[3];
      CC_PL:   return !f[3];
      CC_VS:   return f[1];
      CC_AL:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/fetch_unit_ret_stack.sv
// ret_stack: return-address stack for CALL/RET; only built when FETCH_CALL_EN is defined
`ifdef FETCH_CALL_EN
module ret_stack #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_ptr;
  logic [IW-1:0] w_top, w_wr;
  assign full  = r_ptr == PW'(DEPTH);
  assign empty = r_ptr == '0;
  assign w_top = IW'(r_ptr - 1'b1);
  assign w_wr  = full ? IW'(DEPTH - 1) : r_ptr[IW-1:0];
  assign dout  = empty ? '0 : r_mem[w_top];
  // a push on a full stack overwrites the top entry
  always_ff @(posedge clk)
    if (push) r_mem[w_wr] <= din;
  // pointer saturates at both ends
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_ptr <= '0;
    else if (push && !full) r_ptr <= r_ptr + 1'b1;
    else if (pop && !empty) r_ptr <= r_ptr - 1'b1;
endmodule
`endif

// File: rtl/fetch_unit.sv
// fetch_unit: two-state fetch/issue FSM resolving JMP/BRXX in fetch; optional CALL/RET via FETCH_CALL_EN
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [7:0] RST_VECTOR = 8'h00,
  parameter int         RS_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [7:0]  addr,
  input  logic [15:0] data,
  input  logic [3:0]  flags,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  pc_out
);
  state_t      r_state;
  logic [7:0]  r_pc, r_pc_out;
  logic [15:0] r_ir;
  logic        r_valid;
  logic [4:0]  w_op;
  logic [7:0]  w_imm, w_pc_inc, w_ret_pc, w_next_pc;
  logic        w_jmp, w_br, w_call, w_ret, w_consume;
  assign w_op     = data[15:11];
  assign w_imm    = data[7:0];
  assign w_pc_inc = r_pc + 8'd1;
  assign w_jmp    = w_op == OP_JMP;
  assign w_br     = w_op == OP_BRXX;
`ifdef FETCH_CALL_EN
  logic [7:0] w_rs_dout;
  logic       w_rs_empty, w_rs_full_unused;
  assign w_call = w_op == OP_CALL;
  assign w_ret  = w_op == OP_RET;
  ret_stack #(.DEPTH(RS_DEPTH)) u_ret_stack (
    .clk(clk),
    .reset_n(reset_n),
    .push(r_state == S_FETCH && w_call),
    .pop(r_state == S_FETCH && w_ret),
    .din(w_pc_inc),
    .dout(w_rs_dout),
    .full(w_rs_full_unused),
    .empty(w_rs_empty)
  );
  assign w_ret_pc = w_rs_empty ? RST_VECTOR : w_rs_dout;
`else
  logic w_unused_depth;
  assign w_unused_depth = RS_DEPTH > 0;
  assign w_call   = 1'b0;
  assign w_ret    = 1'b0;
  assign w_ret_pc = RST_VECTOR;
`endif
  assign w_consume = w_jmp || w_br || w_call || w_ret;
  // next fetch address; control-flow words are resolved here and never issued
  always_comb
    w_next_pc = (w_jmp || w_call) ? w_imm :
                w_ret ? w_ret_pc :
                (w_br && cond_taken(cond_t'(data[10:8]), flags)) ? w_imm : w_pc_inc;
  // fetch/issue FSM with registered instruction, address and valid
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state  <= S_FETCH;
      r_pc     <= RST_VECTOR;
      r_ir     <= '0;
      r_pc_out <= '0;
      r_valid  <= 1'b0;
    end else if (r_state == S_FETCH) begin
      r_pc <= w_next_pc;
      if (!w_consume) begin
        r_ir     <= data;
        r_pc_out <= r_pc;
        r_valid  <= 1'b1;
        r_state  <= S_ISSUE;
      end
    end else if (instr_ready) begin
      r_valid <= 1'b0;
      r_state <= S_FETCH;
    end
  assign addr        = r_pc;
  assign instr       = r_ir;
  assign instr_valid = r_valid;
  assign pc_out      = r_pc_out;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: program-walking reference model plus directed vectors for fetch_unit
module tb_fetch_unit;
  import fetch_unit_pkg::*;
  localparam logic [4:0] LDI = 5'h01, ADDI = 5'h02;
  localparam logic [7:0] RV = 8'h00;
  localparam int DEPTH = 4;
  logic clk = 1'b0, reset_n = 1'b0, instr_ready = 1'b1, instr_valid;
  logic [7:0] addr, pc_out;
  logic [15:0] data, instr;
  logic [3:0] flags = 4'h0;
  logic [15:0] mem [256];
  int total = 0, bad = 0;

  always #5 clk = ~clk;
  assign data = mem[addr];

  fetch_unit dut (.clk(clk), .reset_n(reset_n), .addr(addr), .data(data), .flags(flags),
                  .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready), .pc_out(pc_out));

  function automatic logic [15:0] w(logic [4:0] op, logic [2:0] f, logic [7:0] imm);
    return {op, f, imm};
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", n, act, exp, $time);
    end
  endtask

  function automatic bit taken(logic [2:0] cc, logic [3:0] f);
    bit n = f[3], c = f[2], v = f[1], z = f[0];
    case (cc)
      3'd0: return z;
      3'd1: return !z;
      3'd2: return c;
      3'd3: return !c;
      3'd4: return n;
      3'd5: return !n;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  // model: from the next fetch address, walk the program through control-flow words
  // to find the next issued instruction and how many fetch cycles it costs
  int m_wait;
  bit m_first;
  logic [7:0] m_fetch, m_ipc;
  logic [15:0] m_word;
  int stk[$];

  task automatic plan();
    int p, n;
    logic [15:0] x;
    p = int'(m_fetch);
    for (n = 0; n < 600; n++) begin
      x = mem[p];
      if (x[15:11] == OP_JMP) p = int'(x[7:0]);
      else if (x[15:11] == OP_BRXX) p = taken(x[10:8], flags) ? int'(x[7:0]) : (p + 1) % 256;
`ifdef FETCH_CALL_EN
      else if (x[15:11] == OP_CALL) begin
        if (stk.size() == DEPTH) stk[DEPTH-1] = (p + 1) % 256;
        else stk.push_back((p + 1) % 256);
        p = int'(x[7:0]);
      end
      else if (x[15:11] == OP_RET) p = (stk.size() == 0) ? int'(RV) : stk.pop_back();
`endif
      else break;
    end
    m_ipc = 8'(p);
    m_word = mem[p];
    m_wait = (n >= 600) ? 1000000 : n + 1;
    m_first = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_valid", 32'(instr_valid), 0);
      chk("rst_pc_out", 32'(pc_out), 0);
      chk("rst_instr", 32'(instr), 0);
      stk.delete();
      m_fetch = RV;
      plan();
    end else if (m_wait > 0) begin
      if (m_first) chk("fetch_addr", 32'(addr), 32'(m_fetch));
      m_first = 1'b0;
      chk("fetch_idle", 32'(instr_valid), 0);
      m_wait--;
    end else begin
      chk("issue_valid", 32'(instr_valid), 1);
      chk("issue_pc", 32'(pc_out), 32'(m_ipc));
      chk("issue_instr", 32'(instr), 32'(m_word));
      if (instr_ready) begin
        m_fetch = m_ipc + 8'd1;
        plan();
      end
    end
  end

  task automatic hold_reset();
    @(posedge clk);
    #1 reset_n = 1'b0;
    instr_ready = 1'b1;
    flags = 4'h0;
    foreach (mem[i]) mem[i] = 16'h0000;
  endtask

  task automatic release_rst();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  int br_cc [9]  = '{0, 0, 1, 2, 3, 4, 5, 6, 7};
  int br_f  [9]  = '{1, 0, 1, 4, 4, 8, 0, 0, 0};
  int br_to [9]  = '{7, 6, 6, 7, 6, 7, 7, 6, 7};
  int tr_jmp [6] = '{0, 0, 1, 0, 0, 1};

  initial begin
    // straight-line LDIs: one issue every two cycles
    hold_reset();
    mem[0] = w(LDI, 3'd0, 8'h00); mem[1] = w(LDI, 3'd6, 8'h00); mem[2] = w(LDI, 3'd7, 8'h02);
    release_rst();
    @(negedge clk);
    chk("t1_addr0", 32'(addr), 0);
    chk("t1_v0", 32'(instr_valid), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_pc", 32'(pc_out), i);
      chk("t1_v", 32'(instr_valid), 1);
      @(negedge clk);
      chk("t1_gap", 32'(instr_valid), 0);
    end
    // branch condition table: word 5 = BRXX cc 7
    for (int k = 0; k < 9; k++) begin
      hold_reset();
      flags = 4'(br_f[k]);
      mem[0] = w(OP_JMP, 3'd0, 8'h05); mem[5] = w(OP_BRXX, 3'(br_cc[k]), 8'h07);
      mem[6] = w(LDI, 3'd1, 8'h66); mem[7] = w(LDI, 3'd2, 8'h77);
      release_rst();
      @(negedge clk);
      @(negedge clk); chk("br_addr5", 32'(addr), 5);
      @(negedge clk); chk("br_target", 32'(addr), br_to[k]);
      @(negedge clk); chk("br_issue_pc", 32'(pc_out), br_to[k]);
    end
    // JMP costs one extra cycle and is never issued
    hold_reset();
    mem[0] = w(OP_JMP, 3'd0, 8'h05); mem[5] = w(ADDI, 3'd1, 8'h01);
    mem[6] = w(OP_JMP, 3'd0, 8'h03); mem[3] = w(LDI, 3'd2, 8'h09);
    release_rst();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("jmp_valid", 32'(instr_valid), tr_jmp[i]);
      if (i == 2) chk("jmp_pc5", 32'(pc_out), 5);
      if (i == 3) chk("jmp_addr6", 32'(addr), 6);
      if (i == 5) chk("jmp_pc3", 32'(pc_out), 3);
    end
    // stall in ISSUE for 5 cycles
    hold_reset();
    mem[0] = w(LDI, 3'd1, 8'h42);
    instr_ready = 1'b0;
    release_rst();
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(instr_valid), 1);
      chk("stall_instr", 32'(instr), 32'h0942);
      chk("stall_addr", 32'(addr), 1);
    end
    @(posedge clk); #1 instr_ready = 1'b1;
    @(negedge clk); chk("stall_last", 32'(instr_valid), 1);
    @(negedge clk); chk("stall_next_addr", 32'(addr), 1);
    chk("stall_next_v", 32'(instr_valid), 0);
    // wrap at 8'hFF, then reset in the middle of ISSUE
    hold_reset();
    mem[0] = w(OP_JMP, 3'd0, 8'hFF); mem[8'hFF] = w(ADDI, 3'd2, 8'h01);
    release_rst();
    @(negedge clk);
    @(negedge clk); chk("wrap_addr_ff", 32'(addr), 32'hFF);
    @(negedge clk); chk("wrap_pc", 32'(pc_out), 32'hFF);
    chk("wrap_instr", 32'(instr), 32'h1201);
    @(negedge clk); chk("wrap_addr_00", 32'(addr), 0);
    @(posedge clk); #1 instr_ready = 1'b0;
    @(negedge clk);
    @(negedge clk); chk("mid_valid_pre", 32'(instr_valid), 1);
    #2 reset_n = 1'b0;
    #1 chk("mid_valid_drop", 32'(instr_valid), 0);
    chk("mid_pc_out", 32'(pc_out), 0);
    // zero fill issues as an ordinary instruction
    hold_reset();
    release_rst();
    @(negedge clk);
    @(negedge clk); chk("zero_valid", 32'(instr_valid), 1);
    chk("zero_instr", 32'(instr), 0);
    // JMP to self spins in FETCH
    hold_reset();
    mem[0] = w(OP_JMP, 3'd0, 8'h00);
    release_rst();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("self_addr", 32'(addr), 0);
      chk("self_valid", 32'(instr_valid), 0);
    end
`ifdef FETCH_CALL_EN
    begin
      int seq1 [7] = '{0, 4, 20, 20, 21, 5, 5};
      int seq2 [11] = '{0, 10, 20, 30, 40, 50, 41, 21, 11, 1, 0};
      hold_reset();
      mem[0] = w(OP_JMP, 3'd0, 8'd4); mem[4] = w(OP_CALL, 3'd0, 8'd20);
      mem[20] = w(LDI, 3'd1, 8'h11); mem[21] = w(OP_RET, 3'd0, 8'h00); mem[5] = w(LDI, 3'd2, 8'h22);
      release_rst();
      for (int i = 0; i < 7; i++) begin
        @(negedge clk);
        if (i == 3 || i == 6) chk("call_issue_pc", 32'(pc_out), seq1[i]);
        else chk("call_addr", 32'(addr), seq1[i]);
      end
      hold_reset();
      mem[0] = w(OP_CALL, 3'd0, 8'd10); mem[10] = w(OP_CALL, 3'd0, 8'd20);
      mem[20] = w(OP_CALL, 3'd0, 8'd30); mem[30] = w(OP_CALL, 3'd0, 8'd40);
      mem[40] = w(OP_CALL, 3'd0, 8'd50);
      mem[50] = w(OP_RET, 3'd0, 8'h00); mem[41] = w(OP_RET, 3'd0, 8'h00);
      mem[21] = w(OP_RET, 3'd0, 8'h00); mem[11] = w(OP_RET, 3'd0, 8'h00);
      mem[1] = w(OP_RET, 3'd0, 8'h00);
      release_rst();
      for (int i = 0; i < 11; i++) begin
        @(negedge clk);
        chk("nest_addr", 32'(addr), seq2[i]);
      end
    end
`else
    // CALL and RET pass through as ordinary instructions
    hold_reset();
    mem[0] = w(OP_CALL, 3'd0, 8'd20); mem[1] = w(OP_RET, 3'd0, 8'h00);
    release_rst();
    @(negedge clk);
    @(negedge clk); chk("call_issued", 32'(instr), 32'hF014);
    chk("call_pc", 32'(pc_out), 0);
    @(negedge clk);
    @(negedge clk); chk("ret_issued", 32'(instr), 32'hF800);
    chk("ret_pc", 32'(pc_out), 1);
`endif
    hold_reset();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end
endmodule
